// File: rtl/vga_pattern_gen_if.sv
// Pattern-select inputs and video timing/colour outputs of the VGA pattern generator.
// The generator side uses master; a sink or bench uses slave.
interface vga_pattern_gen_if #(
  parameter int COLOR_BITS = 1
);
  logic [2:0]              switch;
  logic [1:0]              mode;
  logic                    hsync;
  logic                    vsync;
  logic [3*COLOR_BITS-1:0] rgb;
  logic                    video_on;
  logic [9:0]              pixel_x;
  logic [9:0]              pixel_y;
  logic                    frame_start;

  modport master (
    input  switch, mode,
    output hsync, vsync, rgb, video_on, pixel_x, pixel_y, frame_start
  );

  modport slave (
    output switch, mode,
    input  hsync, vsync, rgb, video_on, pixel_x, pixel_y, frame_start
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// VGA timing generator with four test patterns (solid, bars, checker, bouncing box).
// Every output is registered from one counter snapshot, so all outputs lag the counters by 1 clk.
module vga_pattern_gen #(
  parameter int H_DISPLAY  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_DISPLAY  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CLK_DIV    = 2,
  parameter int COLOR_BITS = 1,
  parameter bit SYNC_POL   = 1'b0,
  parameter int BOX_SIZE   = 32
) (
  input  logic              clk,
  input  logic              rst,
  vga_pattern_gen_if.master vga
);
  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RGB_W   = 3 * COLOR_BITS;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0]  V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0]  HS_FIRST = 10'(H_DISPLAY + H_FP);
  localparam logic [9:0]  HS_LAST  = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
  localparam logic [9:0]  VS_FIRST = 10'(V_DISPLAY + V_FP);
  localparam logic [9:0]  VS_LAST  = 10'(V_DISPLAY + V_FP + V_SYNC - 1);
  localparam logic [9:0]  BAR_W    = 10'(H_DISPLAY / 8);
  localparam logic [9:0]  X_LIM    = 10'(H_DISPLAY - BOX_SIZE);
  localparam logic [9:0]  Y_LIM    = 10'(V_DISPLAY - BOX_SIZE);
  localparam logic [10:0] BOX_W    = 11'(BOX_SIZE);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d, v_q, v_d;
  logic             wrap_q, wrap_d;
  logic [1:0]       mode_q, mode_d;
  logic [2:0]       sw_q, sw_d;
  logic [9:0]       box_x_q, box_x_d, box_y_q, box_y_d;
  logic             dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d;
  logic             video_q, video_d, fs_q, fs_d;
  logic [9:0]       px_q, px_d, py_q, py_d;
  logic [RGB_W-1:0] rgb_q, rgb_d, rgb_exp;
  logic [2:0]       sel;
  logic             p_tick, h_end, v_end, frame_wrap, in_box;

  always_comb begin
    p_tick     = (div_q == DIV_LAST);
    h_end      = (h_q == H_LAST);
    v_end      = (v_q == V_LAST);
    frame_wrap = p_tick && h_end && v_end;

    div_d = p_tick ? '0 : div_q + 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    if (p_tick) begin
      h_d = h_end ? '0 : h_q + 10'd1;
      if (h_end) v_d = v_end ? '0 : v_q + 10'd1;
    end
    wrap_d = frame_wrap;

    // Pattern inputs and the box move only at the frame boundary, so a frame is never torn.
    mode_d  = mode_q;
    sw_d    = sw_q;
    box_x_d = box_x_q;
    box_y_d = box_y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    if (frame_wrap) begin
      mode_d  = vga.mode;
      sw_d    = vga.switch;
      box_x_d = dir_x_q ? box_x_q + 10'd1 : box_x_q - 10'd1;
      box_y_d = dir_y_q ? box_y_q + 10'd1 : box_y_q - 10'd1;
      dir_x_d = dir_x_q ? (box_x_d != X_LIM) : (box_x_d == '0);
      dir_y_d = dir_y_q ? (box_y_d != Y_LIM) : (box_y_d == '0);
    end

    in_box = (h_q >= box_x_q) && ({1'b0, h_q} < ({1'b0, box_x_q} + BOX_W)) &&
             (v_q >= box_y_q) && ({1'b0, v_q} < ({1'b0, box_y_q} + BOX_W));
    case (mode_q)
      2'd0:    sel = sw_q;
      2'd1:    sel = 3'(h_q / BAR_W);
      2'd2:    sel = (h_q[5] ^ v_q[5]) ? ~sw_q : sw_q;
      default: sel = in_box ? sw_q : 3'b000;
    endcase

    video_d = (h_q < H_VIS) && (v_q < V_VIS);
    hsync_d = ((h_q >= HS_FIRST) && (h_q <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
    vsync_d = ((v_q >= VS_FIRST) && (v_q <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
    px_d    = h_q;
    py_d    = v_q;
    fs_d    = wrap_q;
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    assign rgb_exp[gi*COLOR_BITS +: COLOR_BITS] = {COLOR_BITS{sel[gi]}};
  end

  always_comb begin
    rgb_d = video_d ? rgb_exp : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      wrap_q  <= 1'b0;
      mode_q  <= '0;
      sw_q    <= '0;
      box_x_q <= '0;
      box_y_q <= '0;
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b1;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      video_q <= 1'b0;
      fs_q    <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
      rgb_q   <= '0;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      wrap_q  <= wrap_d;
      mode_q  <= mode_d;
      sw_q    <= sw_d;
      box_x_q <= box_x_d;
      box_y_q <= box_y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      video_q <= video_d;
      fs_q    <= fs_d;
      px_q    <= px_d;
      py_q    <= py_d;
      rgb_q   <= rgb_d;
    end
  end

  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.video_on    = video_q;
  assign vga.frame_start = fs_q;
  assign vga.pixel_x     = px_q;
  assign vga.pixel_y     = py_q;
  assign vga.rgb         = rgb_q;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen on a shrunken raster so that many frames fit in a short run.
// A frame-level reference model checks every clk; a vector table and hand sequences cover corner cases.
module tb_vga_pattern_gen;
  localparam int H_DISPLAY = 40, H_FP = 2, H_SYNC = 4, H_BP = 2;
  localparam int V_DISPLAY = 36, V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int CLK_DIV   = 2;
  localparam int CB        = 2;
  localparam bit SYNC_POL  = 1'b0;
  localparam int BOX       = 32;
  localparam int H_TOTAL   = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int FRAME_CLK = H_TOTAL * V_TOTAL * CLK_DIV;
  localparam logic [29:0] RST_OUT = {1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 6'd0};

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  vga_pattern_gen_if #(.COLOR_BITS(CB)) vga_if ();

  vga_pattern_gen #(
    .H_DISPLAY(H_DISPLAY), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_DISPLAY(V_DISPLAY), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CLK_DIV(CLK_DIV), .COLOR_BITS(CB), .SYNC_POL(SYNC_POL), .BOX_SIZE(BOX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vga(vga_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [2:0] sw;
    int         x;
    int         y;
    logic [5:0] rgb;
  } vec_t;

  vec_t tbl [9];

  // Packed view: {hsync, vsync, video_on, frame_start, pixel_x, pixel_y, rgb}
  function automatic logic [29:0] get_out();
    return {vga_if.hsync, vga_if.vsync, vga_if.video_on, vga_if.frame_start,
            vga_if.pixel_x, vga_if.pixel_y, vga_if.rgb};
  endfunction

  // Position after f frame updates of a point bouncing between 0 and m.
  function automatic int bounce(int f, int m);
    int r;
    r = f % (2 * m);
    return (r <= m) ? r : 2 * m - r;
  endfunction

  // Expected outputs k clk after reset release, given the pattern inputs latched for that frame.
  function automatic logic [29:0] model(int k, logic [1:0] m, logic [2:0] s);
    int pix, h, v, f, bx, by;
    logic vis, hs, vs, fs;
    logic [2:0] c;
    logic [5:0] rgb;
    pix = k / CLK_DIV;
    h   = pix % H_TOTAL;
    v   = (pix / H_TOTAL) % V_TOTAL;
    f   = k / FRAME_CLK;
    bx  = bounce(f, H_DISPLAY - BOX);
    by  = bounce(f, V_DISPLAY - BOX);
    vis = (h < H_DISPLAY) && (v < V_DISPLAY);
    hs  = (h >= H_DISPLAY + H_FP && h < H_DISPLAY + H_FP + H_SYNC) ? SYNC_POL : !SYNC_POL;
    vs  = (v >= V_DISPLAY + V_FP && v < V_DISPLAY + V_FP + V_SYNC) ? SYNC_POL : !SYNC_POL;
    case (m)
      2'd0:    c = s;
      2'd1:    c = 3'(h / (H_DISPLAY / 8));
      2'd2:    c = ((((h / 32) + (v / 32)) % 2) == 1) ? ~s : s;
      default: c = (h >= bx && h < bx + BOX && v >= by && v < by + BOX) ? s : 3'b000;
    endcase
    if (!vis) c = 3'b000;
    rgb = {{2{c[2]}}, {2{c[1]}}, {2{c[0]}}};
    fs  = (k > 0) && (k % FRAME_CLK == 0);
    return {hs, vs, vis, fs, 10'(h), 10'(v), rgb};
  endfunction

  task automatic check(string name, int idx, logic [29:0] act, logic [29:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // The first pulse may come from a wrap that preceded the input change, so it is skipped.
  task automatic wait_fs(string tag);
    int n;
    n = 0;
    step();
    while (!vga_if.frame_start && n < 2 * FRAME_CLK) begin
      step();
      n++;
    end
    if (!vga_if.frame_start) begin
      checks++;
      errors++;
      $display("FAIL %s: no frame_start within %0d clk, required a pulse", tag, n);
    end
  endtask

  task automatic wait_pix(int x, int y, string tag);
    int n;
    n = 0;
    while (!(int'(vga_if.pixel_x) == x && int'(vga_if.pixel_y) == y) && n < FRAME_CLK) begin
      step();
      n++;
    end
    if (n >= FRAME_CLK) begin
      checks++;
      errors++;
      $display("FAIL %s: pixel (%0d,%0d) not reached, at (%0d,%0d)",
               tag, x, y, vga_if.pixel_x, vga_if.pixel_y);
    end
  endtask

  // Caller releases reset just after an edge; clk k here is the k-th edge with rst low.
  task automatic run_model(int n, bit rnd);
    logic [1:0] lm, cm;
    logic [2:0] ls, cs;
    logic [29:0] exp_v;
    lm = 2'd0;
    ls = 3'd0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      cm = vga_if.mode;
      cs = vga_if.switch;
      exp_v = model(k, lm, ls);
      if (k % FRAME_CLK == FRAME_CLK - 1) begin
        lm = cm;
        ls = cs;
      end
      #1;
      check("model", k, get_out(), exp_v);
      if (rnd && $urandom_range(0, 399) == 0) begin
        vga_if.mode   = ($urandom_range(0, 5) > 3) ? 2'd3 : 2'($urandom_range(0, 3));
        vga_if.switch = 3'($urandom_range(0, 7));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    tbl[0] = '{2'd1, 3'b101,  0,  0, 6'b000000};
    tbl[1] = '{2'd1, 3'b101,  5,  3, 6'b000011};
    tbl[2] = '{2'd1, 3'b101, 39, 10, 6'b111111};
    tbl[3] = '{2'd1, 3'b101, 40, 10, 6'b000000};
    tbl[4] = '{2'd2, 3'b100,  0,  0, 6'b110000};
    tbl[5] = '{2'd2, 3'b100, 32,  0, 6'b001111};
    tbl[6] = '{2'd2, 3'b100, 32, 32, 6'b110000};
    tbl[7] = '{2'd0, 3'b011, 10, 20, 6'b001111};
    tbl[8] = '{2'd0, 3'b011,  0, 37, 6'b000000};

    rst           = 1'b1;
    vga_if.mode   = 2'd3;
    vga_if.switch = 3'b111;
    repeat (3) step();
    check("reset_outputs", 0, get_out(), RST_OUT);

    // Free run long enough for the box to hit the right edge and turn back.
    rst = 1'b0;
    run_model(10 * FRAME_CLK + 50, 1'b1);

    for (int i = 0; i < 9; i++) begin
      if (i == 0 || tbl[i].mode != tbl[i-1].mode || tbl[i].sw != tbl[i-1].sw) begin
        vga_if.mode   = tbl[i].mode;
        vga_if.switch = tbl[i].sw;
        wait_fs("tbl_frame");
      end
      wait_pix(tbl[i].x, tbl[i].y, "tbl_pixel");
      check("tbl_rgb", i, 30'(vga_if.rgb), 30'(tbl[i].rgb));
    end

    // Switch changed mid-frame must not show until the next frame.
    vga_if.mode   = 2'd0;
    vga_if.switch = 3'b010;
    wait_fs("midframe_a");
    wait_pix(0, 10, "midframe_line");
    vga_if.switch = 3'b001;
    wait_pix(20, 20, "midframe_pix");
    check("midframe_old_rgb", 0, 30'(vga_if.rgb), 30'(6'b001100));
    wait_fs("midframe_b");
    check("midframe_new_rgb", 0, 30'(vga_if.rgb), 30'(6'b000011));

    // One-clk reset in the middle of a line while the box pattern is active.
    vga_if.mode   = 2'd3;
    vga_if.switch = 3'b111;
    wait_fs("midline_frame");
    wait_pix(30, 20, "midline_pix");
    rst = 1'b1;
    step();
    check("midline_rst_outputs", 0, get_out(), RST_OUT);
    rst = 1'b0;
    run_model(2 * FRAME_CLK + 200, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 Parameter H_DISPLAY, 640, visible pixels per line.
REQ-002 Parameters H_FP/H_SYNC/H_BP, 16/96/48, horizontal front porch/sync/back porch in pixels; H_TOTAL = sum of all four.
REQ-003 Parameters V_DISPLAY/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical equivalents in lines; V_TOTAL = sum.
REQ-004 Parameter CLK_DIV, 2, clk cycles per pixel tick (>=1).
REQ-005 Parameter COLOR_BITS, 1, bits per colour channel.
REQ-006 Parameter SYNC_POL, 0, active level of hsync/vsync.
REQ-007 Parameter BOX_SIZE, 32, moving-box edge length in pixels.
REQ-008 clk  input  1  single system clock; all state changes on rising edge.
REQ-009 rst  input  1  synchronous, active-high reset.
REQ-010 switch  input  3  colour select {R,G,B}.
REQ-011 mode  input  2  pattern select.
REQ-012 hsync, vsync  output  1 each  sync pulses, level per SYNC_POL.
REQ-013 rgb  output  3*COLOR_BITS  {R,G,B}, each channel COLOR_BITS wide.
REQ-014 video_on  output  1  high while the current pixel is visible.
REQ-015 pixel_x, pixel_y  output  10 each  current counter values.
REQ-016 frame_start  output  1  one-clk pulse at the start of each frame.

Function
REQ-017 Divider counts 0..CLK_DIV-1; p_tick is high for one clk when the divider equals CLK_DIV-1.
REQ-018 On p_tick, h_cnt increments and wraps H_TOTAL-1 -> 0; v_cnt increments only on the h_cnt wrap, and wraps V_TOTAL-1 -> 0.
REQ-019 Sync active while h_cnt is in [H_DISPLAY+H_FP, H_DISPLAY+H_FP+H_SYNC-1]; vsync defined the same way with the V parameters.
REQ-020 video_on = (h_cnt < H_DISPLAY) && (v_cnt < V_DISPLAY).
REQ-021 All outputs are registered from the same counter snapshot: 1 clk latency, mutually aligned.
REQ-022 frame_start pulses on the clk where p_tick wraps both counters to (0,0).
REQ-023 mode and switch are latched only on frame_start; mid-frame changes take effect at the next frame only.
REQ-024 Channel expansion: a set switch bit drives all COLOR_BITS of that channel to 1; a clear bit drives them to 0.
REQ-025 Mode 0 (solid): rgb = expanded latched switch.
REQ-026 Mode 1 (bars): bar index i = pixel_x / (H_DISPLAY/8); rgb = expanded i[2:0]; latched switch is ignored.
REQ-027 Mode 2 (checker): if pixel_x[5] XOR pixel_y[5] is 0, rgb = expanded switch; otherwise rgb = expanded ~switch.
REQ-028 Mode 3 (box): inside the box [box_x, box_x+BOX_SIZE) x [box_y, box_y+BOX_SIZE), rgb = expanded switch; outside, rgb = 0.
REQ-029 On each frame_start, box_x moves 1 pixel in dir_x and box_y moves 1 pixel in dir_y.
REQ-030 The box direction reverses on the same update that reaches a boundary: 0 or H_DISPLAY-BOX_SIZE for x; 0 or V_DISPLAY-BOX_SIZE for y.
REQ-031 The box never leaves the visible area; box position updates in all modes.
REQ-032 rgb = 0 whenever video_on = 0, regardless of mode.

Reset
REQ-033 While rst is high at a clk edge, the divider, h_cnt, v_cnt, pixel_x and pixel_y are cleared to 0.
REQ-034 During reset, hsync and vsync are driven inactive (~SYNC_POL) and rgb, video_on and frame_start are driven 0.
REQ-035 Reset sets latched mode and switch to 0, box to (0,0), and dir_x/dir_y to +.
REQ-036 Reset mid-frame aborts the frame; the first post-reset pixel is (0,0), with no frame_start pulse for that pixel.

Verification
REQ-037 Defaults, free-run after reset -> hsync low for 192 clk every 1600 clk; vsync low for 3200 clk every 840000 clk; frame_start period 840000 clk.
REQ-038 mode=1 -> rgb=3'b000 for pixel_x 0..79, 3'b001 for 80..159, 3'b111 for 560..639; rgb=0 for pixel_x >= 640.
REQ-039 mode=2, switch=3'b100 -> rgb=3'b100 at (0,0), 3'b011 at (32,0), 3'b100 at (32,32).
REQ-040 mode=0, switch changed 3'b010 -> 3'b001 at line 100 -> rgb stays 3'b010 until frame_start, then 3'b001.
REQ-041 mode=3, after reset -> box at (0,0) on frame 1 and (1,1) on frame 2; when box_x reaches 608, the next frame gives box_x = 607.
REQ-042 rst pulsed for 1 clk mid-line (h_cnt=300, v_cnt=200) -> next outputs show pixel (0,0), syncs inactive, rgb 0 during reset, and the box returns to (0,0).
